// File: rtl/mem_stage.sv
// Memory stage: word-organised data memory behind a wait-state FSM, feeding a registered MEM/WB boundary.
// Handshake: ready=1 means the presented instruction commits on this rising edge; ready=0 means upstream holds all inputs.
module mem_stage #(
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] alu_res,
    input  logic [31:0] Val_Rm,
    input  logic [3:0]  Dest,
    output logic        ready,
    output logic        WB_EN_out,
    output logic        MEM_R_EN_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  Dest_out,
    output logic        addr_err,
    output logic        state_dbg
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              fsm_ready;
    logic              mem_req;
    logic [31:0]       byte_off;
    logic [31:0]       word_off;
    logic [IDX_W-1:0]  idx;
    logic              addr_ok;
    logic [31:0]       rd_data;
    logic [31:0]       mem_q [DEPTH];

    assign mem_req  = MEM_R_EN | MEM_W_EN;
    assign byte_off = alu_res - 32'(BASE_ADDR);
    assign word_off = byte_off >> 2;
    assign idx      = word_off[IDX_W-1:0];
    assign addr_ok  = (alu_res >= 32'(BASE_ADDR)) && (word_off < 32'(DEPTH)) &&
                      (alu_res[1:0] == 2'b00);
    assign rd_data  = addr_ok ? mem_q[idx] : 32'h0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fsm_ready = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (mem_req && (WAIT_CYCLES > 0)) begin
                    fsm_ready = 1'b0;
                    cnt_d     = 4'(WAIT_CYCLES - 1);
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    fsm_ready = 1'b0;
                    cnt_d     = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Held in reset the stage reports ready so upstream is never frozen by a dead access.
    assign ready     = fsm_ready | ~rst;
    assign state_dbg = (state_q == BUSY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The array has no reset; the rst term also drops any write while reset is held.
    always_ff @(posedge clk) begin
        if (rst && fsm_ready && MEM_W_EN && addr_ok) begin
            mem_q[idx] <= Val_Rm;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            alu_res_out  <= 32'h0;
            mem_data_out <= 32'h0;
            Dest_out     <= 4'h0;
            addr_err     <= 1'b0;
        end else if (fsm_ready) begin
            WB_EN_out    <= WB_EN_in;
            MEM_R_EN_out <= MEM_R_EN;
            alu_res_out  <= alu_res;
            Dest_out     <= Dest;
            mem_data_out <= MEM_R_EN ? rd_data : 32'h0;
            addr_err     <= mem_req & ~addr_ok;
        end else begin
            // Stall edge: emit a bubble so each instruction writes back exactly once.
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            addr_err     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a WAIT_CYCLES=3 instance (index 0) and a WAIT_CYCLES=0 instance (index 1).
// Drivers push expected write-back entries; a negedge monitor pops and compares them.
module tb_mem_stage;

  localparam int EW = 71;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wb_en [2];
  logic        mr_en [2];
  logic        mw_en [2];
  logic [31:0] alu   [2];
  logic [31:0] rm    [2];
  logic [3:0]  dest  [2];
  logic        rdy   [2];
  logic        wb_o  [2];
  logic        mr_o  [2];
  logic        err_o [2];
  logic        busy_o[2];
  logic [31:0] alu_o [2];
  logic [31:0] data_o[2];
  logic [3:0]  dest_o[2];

  mem_stage #(.WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst), .WB_EN_in(wb_en[0]), .MEM_R_EN(mr_en[0]), .MEM_W_EN(mw_en[0]),
    .alu_res(alu[0]), .Val_Rm(rm[0]), .Dest(dest[0]), .ready(rdy[0]), .WB_EN_out(wb_o[0]),
    .MEM_R_EN_out(mr_o[0]), .alu_res_out(alu_o[0]), .mem_data_out(data_o[0]),
    .Dest_out(dest_o[0]), .addr_err(err_o[0]), .state_dbg(busy_o[0])
  );

  mem_stage #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .WB_EN_in(wb_en[1]), .MEM_R_EN(mr_en[1]), .MEM_W_EN(mw_en[1]),
    .alu_res(alu[1]), .Val_Rm(rm[1]), .Dest(dest[1]), .ready(rdy[1]), .WB_EN_out(wb_o[1]),
    .MEM_R_EN_out(mr_o[1]), .alu_res_out(alu_o[1]), .mem_data_out(data_o[1]),
    .Dest_out(dest_o[1]), .addr_err(err_o[1]), .state_dbg(busy_o[1])
  );

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] mon_got;
  logic [EW-1:0] mon_exp;

  function automatic logic [EW-1:0] pack(input logic wb, input logic mr, input logic err,
                                         input logic [3:0] d, input logic [31:0] a,
                                         input logic [31:0] m);
    return {wb, mr, err, d, a, m};
  endfunction

  function automatic logic [EW-1:0] out_vec(input int d);
    return pack(wb_o[d], mr_o[d], err_o[d], dest_o[d], alu_o[d], data_o[d]);
  endfunction

  task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: every write-back slot (WB_EN_out or addr_err) must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        if (wb_o[d] || err_o[d]) begin
          mon_got = out_vec(d);
          if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_wb[%0d]: got %h, expected no entry", d, mon_got);
          end else begin
            mon_exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("wb_entry[%0d]", d), mon_got, mon_exp);
          end
        end
      end
    end
  end

  task automatic idle(input int d);
    wb_en[d] = 1'b0; mr_en[d] = 1'b0; mw_en[d] = 1'b0;
    alu[d] = 32'h0; rm[d] = 32'h0; dest[d] = 4'h0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the commit edge with the inputs idled.
  task automatic issue(input int d, input logic wb, input logic mr, input logic mw,
                       input logic [31:0] a, input logic [31:0] v, input logic [3:0] ds,
                       input int exp_stall, input bit has_out, input logic [EW-1:0] exp);
    int stalls;
    bit done;
    stalls = 0;
    done = 1'b0;
    wb_en[d] = wb; mr_en[d] = mr; mw_en[d] = mw; alu[d] = a; rm[d] = v; dest[d] = ds;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rdy[d]) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout[%0d]: got no ready in 40 cycles, expected %0d stalls", d, exp_stall);
    end
    check($sformatf("stall_cycles[%0d] @%0d", d, a), EW'(stalls), EW'(exp_stall));
    @(posedge clk);
    #1;
    if (has_out) begin
      if (d == 0) exp_q0.push_back(exp);
      else exp_q1.push_back(exp);
    end
    idle(d);
  endtask

  initial begin
    idle(0);
    idle(1);
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    check("reset_outputs_w3", out_vec(0), '0);
    check("reset_outputs_w0", out_vec(1), '0);
    check("reset_ready", EW'({rdy[0], rdy[1], busy_o[0], busy_o[1]}), EW'(4'b1100));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Seed words used later
    issue(0, 0, 0, 1, 32'd1028, 32'h1111_1111, 4'd0, 3, 0, '0);
    issue(0, 0, 0, 1, 32'd1032, 32'h2222_2222, 4'd0, 3, 0, '0);

    // Store then load at the base address
    issue(0, 0, 0, 1, 32'd1024, 32'hDEAD_BEEF, 4'd0, 3, 0, '0);
    issue(0, 1, 1, 0, 32'd1024, 32'h0, 4'd5, 3, 1, pack(1, 1, 0, 4'd5, 32'd1024, 32'hDEAD_BEEF));

    // Non-memory op passes straight through
    issue(0, 1, 0, 0, 32'd5, 32'h0, 4'd3, 0, 1, pack(1, 0, 0, 4'd3, 32'd5, 32'h0));

    // Invalid addresses: below base, misaligned, one past the end (would alias word 0)
    issue(0, 1, 1, 0, 32'd1020, 32'h0, 4'd7, 3, 1, pack(1, 1, 1, 4'd7, 32'd1020, 32'h0));
    issue(0, 1, 1, 0, 32'd1026, 32'h0, 4'd8, 3, 1, pack(1, 1, 1, 4'd8, 32'd1026, 32'h0));
    issue(0, 0, 0, 1, 32'd1280, 32'h99, 4'd0, 3, 1, pack(0, 0, 1, 4'd0, 32'd1280, 32'h0));
    issue(0, 1, 1, 0, 32'd1024, 32'h0, 4'd9, 3, 1, pack(1, 1, 0, 4'd9, 32'd1024, 32'hDEAD_BEEF));

    // Last valid word
    issue(0, 0, 0, 1, 32'd1276, 32'h7E7E_7E7E, 4'd0, 3, 0, '0);
    issue(0, 1, 1, 0, 32'd1276, 32'h0, 4'd10, 3, 1, pack(1, 1, 0, 4'd10, 32'd1276, 32'h7E7E_7E7E));

    // Load and store together: old word returned, new word stored
    issue(0, 1, 1, 1, 32'd1032, 32'h3333_3333, 4'd2, 3, 1, pack(1, 1, 0, 4'd2, 32'd1032, 32'h2222_2222));

    // Reset in the second BUSY cycle of a store abandons it
    wb_en[0] = 1'b0; mr_en[0] = 1'b0; mw_en[0] = 1'b1;
    alu[0] = 32'd1028; rm[0] = 32'h1; dest[0] = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_before_reset", EW'({busy_o[0], rdy[0]}), EW'(2'b10));
    rst = 1'b0;
    #1;
    check("reset_mid_busy_ready", EW'(rdy[0]), EW'(1'b1));
    check("reset_mid_busy_outputs", out_vec(0), '0);
    @(posedge clk); #1;
    idle(0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    issue(0, 1, 1, 0, 32'd1028, 32'h0, 4'd11, 3, 1, pack(1, 1, 0, 4'd11, 32'd1028, 32'h1111_1111));

    // Back-to-back loads with no idle gap
    issue(0, 1, 1, 0, 32'd1028, 32'h0, 4'd12, 3, 1, pack(1, 1, 0, 4'd12, 32'd1028, 32'h1111_1111));
    issue(0, 1, 1, 0, 32'd1032, 32'h0, 4'd13, 3, 1, pack(1, 1, 0, 4'd13, 32'd1032, 32'h3333_3333));

    // Zero-wait build: single-cycle store then load
    issue(1, 0, 0, 1, 32'd1100, 32'hA5A5_A5A5, 4'd0, 0, 0, '0);
    issue(1, 1, 1, 0, 32'd1100, 32'h0, 4'd4, 0, 1, pack(1, 1, 0, 4'd4, 32'd1100, 32'hA5A5_A5A5));

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained_w3", EW'(exp_q0.size()), '0);
    check("queue_drained_w0", EW'(exp_q1.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, expected finish");
    $fatal(1, "timeout");
  end

endmodule
